// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and sizing for the read-side burst consumer of the async FIFO.
package fifo_rd_pkg;
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);
endpackage

// File: rtl/fifo_burst_reader_if.sv
// Command, FIFO read port and output stream of the burst reader, bundled as one interface.
interface fifo_burst_reader_if #(
  parameter int DATASIZE = 8,
  parameter int LEN_BITS = 8
);
  logic                start;
  logic [LEN_BITS-1:0] burst_len;
  logic                rempty;
  logic [DATASIZE-1:0] read_data;
  logic                read_inc;
  logic [DATASIZE-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                done;

  modport master (
    output start, burst_len, rempty, read_data, out_ready,
    input  read_inc, out_data, out_valid, busy, done
  );

  modport slave (
    input  start, burst_len, rempty, read_data, out_ready,
    output read_inc, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/fifo_burst_reader_skid_buf.sv
// Two-entry in-order buffer between the FIFO pop and the valid/ready output stream.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATASIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic [DATASIZE-1:0] i_data,
  input  logic                i_pop,
  output logic [DATASIZE-1:0] o_head,
  output logic                o_valid,
  output logic [OCC_W-1:0]    o_occ
);
  logic [DATASIZE-1:0] r_mem [BUF_DEPTH];
  logic                r_head;
  logic [OCC_W-1:0]    r_occ;
  logic                w_tail;

  // With two slots the tail sits at head+occ mod 2; a push during a pop at occ==2 reuses the slot being freed.
  assign w_tail = r_head ^ r_occ[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_head <= 1'b0;
      r_occ  <= '0;
    end else begin
      if (i_push) r_mem[w_tail] <= i_data;
      if (i_pop)  r_head <= ~r_head;
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_valid = (r_occ != '0);
  assign o_occ   = r_occ;
endmodule

// File: rtl/fifo_burst_reader.sv
// Pops burst_len words from the FIFO read port and streams them out in order, pulsing done at the end.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATASIZE     = 8,
  parameter int ADDRESS_BITS = 4,
  parameter int LEN_BITS     = 8
) (
  input logic                read_clk,
  input logic                read_rst,
  fifo_burst_reader_if.slave bus
);
  if (ADDRESS_BITS < 1) begin : g_bad_addr
    $error("ADDRESS_BITS must be positive");
  end

  rd_state_t           r_state;
  rd_state_t           w_state_nxt;
  logic [LEN_BITS-1:0] r_pop_left;
  logic [LEN_BITS-1:0] r_dlv_left;
  logic                r_done;
  logic                w_pop;
  logic                w_accept;
  logic                w_done_nxt;
  logic                w_valid;
  logic [DATASIZE-1:0] w_head;
  logic [OCC_W-1:0]    w_occ;

  rd_skid_buf #(.DATASIZE(DATASIZE)) u_buf (
    .clk     (read_clk),
    .rst_n   (read_rst),
    .i_push  (w_pop),
    .i_data  (bus.read_data),
    .i_pop   (w_accept),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_occ   (w_occ)
  );

  assign w_accept = w_valid && bus.out_ready;

  always_ff @(posedge read_clk) begin
    if (!read_rst) r_state <= RD_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RD_IDLE:  if (bus.start && bus.burst_len != '0) w_state_nxt = RD_READ;
      RD_READ:  if (w_pop && r_pop_left == LEN_BITS'(1)) w_state_nxt = RD_DRAIN;
      RD_DRAIN: if (w_accept && r_dlv_left == LEN_BITS'(1)) w_state_nxt = RD_IDLE;
      default:  w_state_nxt = RD_IDLE;
    endcase
  end

  // A full buffer may still take a word when its head leaves on the same edge.
  always_comb begin
    w_pop = 1'b0;
    if (read_rst && r_state == RD_READ && !bus.rempty && r_pop_left != '0 &&
        (w_occ != OCC_FULL || w_accept))
      w_pop = 1'b1;
    w_done_nxt = (r_state == RD_IDLE && bus.start && bus.burst_len == '0) ||
                 (r_state == RD_DRAIN && w_accept && r_dlv_left == LEN_BITS'(1));
  end

  always_ff @(posedge read_clk) begin
    if (!read_rst) begin
      r_pop_left <= '0;
      r_dlv_left <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (r_state == RD_IDLE) begin
        if (bus.start) begin
          r_pop_left <= bus.burst_len;
          r_dlv_left <= bus.burst_len;
        end
      end else begin
        if (w_pop)    r_pop_left <= r_pop_left - LEN_BITS'(1);
        if (w_accept) r_dlv_left <= r_dlv_left - LEN_BITS'(1);
      end
    end
  end

  assign bus.read_inc  = w_pop;
  assign bus.out_data  = w_head;
  assign bus.out_valid = w_valid;
  assign bus.busy      = (r_state != RD_IDLE);
  assign bus.done      = r_done;

  a_no_pop_when_empty: assert property (@(posedge read_clk) !(bus.read_inc && bus.rempty));
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO and stream scoreboard, a directed table, corner sequences and random bursts.
module tb_fifo_burst_reader;
  logic clk = 1'b0;
  logic read_rst;

  fifo_burst_reader_if #(.DATASIZE(8), .LEN_BITS(8)) bus ();

  fifo_burst_reader #(.DATASIZE(8), .ADDRESS_BITS(4), .LEN_BITS(8)) dut (
    .read_clk (clk),
    .read_rst (read_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       st;
    logic [7:0] len;
    logic       rdy;
    logic       e_inc;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl [10];

  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];
  int  m_pops, m_acc, m_len;
  bit  m_active, m_done_nxt;
  int  n_vec, n_err;
  int  obs_pops, obs_done;
  bit  s_st, s_rdy, s_rstn, s_inc, s_valid;
  logic [7:0] s_len;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, then compare the DUT against the abstract burst model.
  task automatic apply(input bit st, input logic [7:0] len, input bit rdy, input bit rstn);
    int occ_m;
    bus.rempty    = (fifo_q.size() == 0);
    bus.read_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    bus.start     = st;
    bus.burst_len = len;
    bus.out_ready = rdy;
    read_rst      = rstn;
    s_st = st; s_len = len; s_rdy = rdy; s_rstn = rstn;
    #1;
    occ_m   = m_pops - m_acc;
    s_inc   = rstn && m_active && (m_pops < m_len) && (fifo_q.size() != 0) && (occ_m < 2 || rdy);
    s_valid = (occ_m != 0);
    chk("read_inc", bus.read_inc, s_inc);
    chk("pop_on_empty", bus.read_inc & bus.rempty, 0);
    if (rstn) begin
      chk("out_valid", bus.out_valid, s_valid);
      chk("busy", bus.busy, m_active);
      chk("done", bus.done, m_done_nxt);
      if (s_valid) chk("out_data", bus.out_data, exp_q[0]);
      if (bus.read_inc) obs_pops++;
      if (bus.done)     obs_done++;
    end
  endtask

  task automatic clock_edge();
    bit was, acc;
    @(posedge clk);
    #1;
    if (!s_rstn) begin
      m_active = 0; m_done_nxt = 0; m_pops = 0; m_acc = 0;
      exp_q.delete();
    end else begin
      was = m_active;
      acc = s_valid && s_rdy;
      m_done_nxt = 0;
      if (s_inc) begin exp_q.push_back(fifo_q.pop_front()); m_pops++; end
      if (acc)   begin void'(exp_q.pop_front()); m_acc++; end
      if (was) begin
        if (m_acc == m_len) begin m_active = 0; m_done_nxt = 1; end
      end else if (s_st) begin
        if (s_len == 8'd0) m_done_nxt = 1;
        else begin m_active = 1; m_len = int'(s_len); m_pops = 0; m_acc = 0; end
      end
    end
  endtask

  task automatic step(input bit st, input logic [7:0] len, input bit rdy, input bit rstn);
    apply(st, len, rdy, rstn);
    clock_edge();
  endtask

  task automatic run_idle(input bit rnd, input int budget, input string nm);
    int n = 0;
    while ((m_active || m_done_nxt) && n < budget) begin
      step(1'b0, 8'h00, rnd ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b1);
      n++;
    end
    chk({nm, "_bound"}, n < budget, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0, d0, n;
    logic [7:0] L;
    n_vec = 0; n_err = 0; obs_pops = 0; obs_done = 0;
    m_pops = 0; m_acc = 0; m_len = 0; m_active = 0; m_done_nxt = 0;

    //          st    len   rdy   inc   vld   data   busy  done
    tbl[0] = {1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = {1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = {1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
    tbl[3] = {1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0};
    tbl[4] = {1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0};
    tbl[5] = {1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[6] = {1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7] = {1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[8] = {1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[9] = {1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b1, 1'b1);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    clock_edge();

    // Three-word burst at full rate, then a zero-length start with data waiting in the FIFO.
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    for (int i = 0; i < 10; i++) begin
      if (i == 7) fifo_q.push_back(8'h44);
      apply(tbl[i].st, tbl[i].len, tbl[i].rdy, 1'b1);
      chk($sformatf("tbl%0d_read_inc", i), bus.read_inc, tbl[i].e_inc);
      chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_done", i), bus.done, tbl[i].e_done);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].e_data);
      clock_edge();
    end
    fifo_q.delete();

    // Downstream stalled: only two words may be taken until it releases.
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'hA0 + i));
    p0 = obs_pops; d0 = obs_done;
    step(1'b1, 8'd5, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_stall_pops", obs_pops - p0, 2);
    chk("t2_hold_data", bus.out_data, 8'hA0);
    clock_edge();
    run_idle(1'b0, 60, "t2");
    chk("t2_pops", obs_pops - p0, 5);
    chk("t2_done", obs_done - d0, 1);

    // FIFO runs dry mid-burst and refills twenty cycles later.
    fifo_q.push_back(8'h51);
    p0 = obs_pops; d0 = obs_done;
    step(1'b1, 8'd4, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (i == 20) begin
        chk("t3_no_done_gap", obs_done - d0, 0);
        chk("t3_gap_pops", obs_pops - p0, 1);
        fifo_q.push_back(8'h52); fifo_q.push_back(8'h53); fifo_q.push_back(8'h54);
      end
      step(1'b0, 8'h00, 1'b1, 1'b1);
    end
    run_idle(1'b0, 20, "t3");
    chk("t3_pops", obs_pops - p0, 4);
    chk("t3_done", obs_done - d0, 1);

    // Reset with a full buffer mid-read, then a fresh two-word burst.
    fifo_q.delete();
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h61 + i));
    step(1'b1, 8'd5, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_full_valid", bus.out_valid, 1);
    chk("t5_full_busy", bus.busy, 1);
    clock_edge();
    d0 = obs_done;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_rst_valid", bus.out_valid, 0);
    chk("t5_rst_busy", bus.busy, 0);
    clock_edge();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t5_no_done", obs_done - d0, 0);
    p0 = obs_pops;
    apply(1'b1, 8'd2, 1'b1, 1'b1);
    clock_edge();
    apply(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t5_first_pop_data", bus.read_data, 8'h63);
    clock_edge();
    run_idle(1'b0, 20, "t5");
    chk("t5_pops", obs_pops - p0, 2);
    chk("t5_done", obs_done - d0, 1);

    // Restart attempts while busy must be ignored.
    fifo_q.delete();
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h71 + i));
    p0 = obs_pops; d0 = obs_done;
    step(1'b1, 8'd4, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'd7, 1'b1, 1'b1);
    step(1'b1, 8'd7, 1'b0, 1'b1);
    run_idle(1'b0, 30, "t6");
    chk("t6_pops", obs_pops - p0, 4);
    chk("t6_done", obs_done - d0, 1);

    // Random bursts with bursty FIFO fill and downstream back-pressure; the first is maximum length.
    fifo_q.delete();
    for (int b = 0; b < 12; b++) begin
      L = (b == 0) ? 8'hFF : 8'($urandom_range(0, 10));
      p0 = obs_pops; d0 = obs_done;
      step(1'b1, L, 1'b1, 1'b1);
      n = 0;
      while ((m_active || m_done_nxt) && n < 3000) begin
        if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) fifo_q.push_back(8'($urandom));
        step(m_active && ($urandom_range(0, 9) == 0), 8'($urandom), $urandom_range(0, 3) != 0, 1'b1);
        n++;
      end
      chk("rnd_bound", n < 3000, 1);
      chk("rnd_pops", obs_pops - p0, 32'(L));
      chk("rnd_done", obs_done - d0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side consumer for the asynchronous FIFO, operating entirely in the read clock domain.
- On a start command it pops exactly burst_len words from the FIFO read port (rempty / read_inc / read_data).
- Popped words are delivered in order on a valid/ready output stream through a 2-entry buffer.
- Signals done when the last word has been accepted downstream.

Parameters:
- DATASIZE, 8, width of a FIFO word and of out_data.
- ADDRESS_BITS, 4, FIFO address width; carried only for consistency with the FIFO instance, no functional effect.
- LEN_BITS, 8, width of burst_len and of the internal counters.

Ports:
- read_clk  input  1  read-domain clock; all logic on rising edge.
- read_rst  input  1  synchronous, active-low reset; sampled on read_clk.
- start  input  1  single-cycle request to begin a burst; ignored unless idle.
- burst_len  input  LEN_BITS  number of words to read; sampled when start is accepted.
- rempty  input  1  FIFO empty flag (read domain).
- read_data  input  DATASIZE  FIFO word at the current read address; combinational, valid in the same cycle as read_inc.
- read_inc  output  1  FIFO pop; combinational.
- out_data  output  DATASIZE  head word of the buffer.
- out_valid  output  1  buffer holds at least one word.
- out_ready  input  1  downstream accept.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the burst completes.

Behaviour:
Reset (read_rst==0 at an edge):
- State RD_IDLE; pop counter, delivered counter and occupancy (occ) all 0.
- Buffer entries, out_data, out_valid, busy and done all 0.
- read_inc is 0 while read_rst==0.

FSM states: RD_IDLE, RD_READ, RD_DRAIN.
- RD_IDLE, start=1, burst_len!=0: latch pop_left=burst_len, go to RD_READ, busy=1 from the next cycle.
- RD_IDLE, start=1, burst_len==0: no FIFO access; done=1 in the next cycle; stay in RD_IDLE; busy stays 0.
- RD_READ: when the pop that brings pop_left to 0 occurs, go to RD_DRAIN.
- RD_DRAIN: when occ becomes 0 (last word accepted), go to RD_IDLE; done=1 and busy=0 in the following cycle.
- start while busy is ignored, with no effect on counters.

Pop rule:
- read_inc = (state==RD_READ) && !rempty && (pop_left!=0) && (occ<2 || (out_valid && out_ready)).
- On a pop, read_data is written into the buffer tail at the same edge, and pop_left decrements.

Output handshake:
- A word transfers on any edge where out_valid && out_ready.
- out_data and out_valid are held stable while out_valid && !out_ready.
- Simultaneous pop and accept with occ==2 or occ==1: occ unchanged, strict FIFO order kept.

Latency:
- A word popped at edge k into an empty buffer appears on out_data with out_valid=1 after edge k.
- Full throughput of 1 word/cycle when FIFO is non-empty and out_ready is held 1.

Boundary conditions:
- rempty rising mid-burst: stall with no pop, state held, resume when rempty falls.
- out_ready low: at most 2 words buffered, then popping stops.
- burst_len at its maximum (2^LEN_BITS-1) must complete without counter wrap.
- Reset mid-burst: buffered words are discarded and no done pulse is issued; FIFO pointers are untouched.
- read_inc is never asserted while rempty==1 (assertion).

Decomposition:
- Package fifo_rd_pkg: typedef enum rd_state_t {RD_IDLE, RD_READ, RD_DRAIN}; localparam BUF_DEPTH=2.
- Sub-module rd_skid_buf: 2-entry synchronous buffer with push/pop, occ, head output and the same reset; instantiated once.
- Top level holds the FSM, counters and read_inc logic.

Test Plan:
1. FIFO pre-filled with 0x11,0x22,0x33, out_ready=1, start with burst_len=3 -> read_inc high 3 consecutive cycles; out_data 0x11,0x22,0x33 on consecutive cycles; done pulse 1 cycle after the last accept; FIFO rempty=1.
2. 5 words queued, burst_len=5, out_ready=0 for 10 cycles then 1 -> exactly 2 pops, occ=2, out_data held at the first word; after release all 5 delivered in order, then done.
3. burst_len=4, FIFO holds 1 word, remaining 3 written 20 read cycles later -> read_inc only while rempty=0; no pop during the gap; busy stays 1; done after the 4th accept.
4. start with burst_len=0 -> read_inc never asserted; done=1 next cycle; busy never 1.
5. Reset asserted (read_rst=0) during RD_READ with occ=2 -> next cycle out_valid=0, busy=0, no done; a new start with burst_len=2 then reads the next two FIFO words correctly.
6. start pulsed again mid-burst with burst_len=7 -> ignored; original burst length completes; only one done pulse.
